// File: rtl/am_search_engine.sv
// Associative-memory search engine: streams a class range out of an external AM,
// scores each entry by popcount(query & entry) and reports the best match; also trains by writing.
module am_search_engine #(
    parameter int HV_LENGTH     = 2048,
    parameter int AM_ADDR_WIDTH = 13,
    parameter int CLASS_WIDTH   = 8,
    localparam int SCORE_WIDTH  = $clog2(HV_LENGTH + 1)
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     soft_clear,
    input  logic                     query_valid,
    output logic                     query_ready,
    input  logic [HV_LENGTH-1:0]     query_hv,
    input  logic                     query_write,
    input  logic [AM_ADDR_WIDTH-1:0] addr_base,
    input  logic [AM_ADDR_WIDTH-1:0] addr_max,
    input  logic [SCORE_WIDTH-1:0]   min_score,
    output logic [AM_ADDR_WIDTH-1:0] am_addr,
    output logic                     am_ren,
    input  logic [HV_LENGTH-1:0]     am_rdata,
    output logic                     am_wen,
    output logic [AM_ADDR_WIDTH-1:0] am_waddr,
    output logic [HV_LENGTH-1:0]     am_wdata,
    output logic                     result_valid,
    input  logic                     result_ready,
    output logic [CLASS_WIDTH-1:0]   result_class,
    output logic [SCORE_WIDTH-1:0]   result_score,
    output logic                     result_match,
    output logic                     result_is_write
);

    typedef enum logic [2:0] {IDLE, READ, DRAIN, WRITE, DONE} state_t;

    state_t                   state;
    logic [HV_LENGTH-1:0]     hv_q;
    logic [AM_ADDR_WIDTH-1:0] base_q;
    logic [AM_ADDR_WIDTH-1:0] max_q;
    logic [SCORE_WIDTH-1:0]   min_q;
    logic                     rd_vld;
    logic [CLASS_WIDTH-1:0]   rd_cls;
    logic                     have_best;
    logic [SCORE_WIDTH-1:0]   best_score;
    logic [CLASS_WIDTH-1:0]   best_cls;

    logic [SCORE_WIDTH-1:0]   score;
    logic                     upd;
    logic [SCORE_WIDTH-1:0]   nb_score;
    logic [CLASS_WIDTH-1:0]   nb_cls;

    function automatic logic [SCORE_WIDTH-1:0] popcnt(input logic [HV_LENGTH-1:0] v);
        logic [SCORE_WIDTH-1:0] c;
        c = '0;
        for (int i = 0; i < HV_LENGTH; i++) c = c + SCORE_WIDTH'(v[i]);
        return c;
    endfunction

    // Strictly-greater update keeps the lowest address on ties.
    always_comb begin
        score    = popcnt(hv_q & am_rdata);
        upd      = rd_vld && (!have_best || (score > best_score));
        nb_score = upd ? score  : best_score;
        nb_cls   = upd ? rd_cls : best_cls;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state           <= IDLE;
            query_ready     <= 1'b1;
            hv_q            <= '0;
            base_q          <= '0;
            max_q           <= '0;
            min_q           <= '0;
            am_addr         <= '0;
            am_ren          <= 1'b0;
            am_wen          <= 1'b0;
            am_waddr        <= '0;
            am_wdata        <= '0;
            rd_vld          <= 1'b0;
            rd_cls          <= '0;
            have_best       <= 1'b0;
            best_score      <= '0;
            best_cls        <= '0;
            result_valid    <= 1'b0;
            result_class    <= '0;
            result_score    <= '0;
            result_match    <= 1'b0;
            result_is_write <= 1'b0;
        end else if (soft_clear) begin
            state           <= IDLE;
            query_ready     <= 1'b1;
            am_addr         <= '0;
            am_ren          <= 1'b0;
            am_wen          <= 1'b0;
            am_waddr        <= '0;
            am_wdata        <= '0;
            rd_vld          <= 1'b0;
            rd_cls          <= '0;
            have_best       <= 1'b0;
            best_score      <= '0;
            best_cls        <= '0;
            result_valid    <= 1'b0;
            result_class    <= '0;
            result_score    <= '0;
            result_match    <= 1'b0;
            result_is_write <= 1'b0;
        end else begin
            // Read-return pipeline: data for the address issued last cycle is scored now.
            rd_vld <= am_ren;
            rd_cls <= CLASS_WIDTH'(am_addr - base_q);
            if (rd_vld) begin
                have_best  <= 1'b1;
                best_score <= nb_score;
                best_cls   <= nb_cls;
            end

            case (state)
                IDLE: begin
                    if (query_valid) begin
                        query_ready <= 1'b0;
                        hv_q        <= query_hv;
                        base_q      <= addr_base;
                        max_q       <= addr_max;
                        min_q       <= min_score;
                        have_best   <= 1'b0;
                        best_score  <= '0;
                        best_cls    <= '0;
                        if (query_write) begin
                            state    <= WRITE;
                            am_wen   <= 1'b1;
                            am_waddr <= addr_base;
                            am_wdata <= query_hv;
                        end else if (addr_base <= addr_max) begin
                            state   <= READ;
                            am_ren  <= 1'b1;
                            am_addr <= addr_base;
                        end else begin
                            state        <= DONE;
                            result_valid <= 1'b1;
                        end
                    end
                end
                READ: begin
                    if (am_addr == max_q) begin
                        state   <= DRAIN;
                        am_ren  <= 1'b0;
                        am_addr <= '0;
                    end else begin
                        am_addr <= am_addr + 1'b1;
                    end
                end
                DRAIN: begin
                    state        <= DONE;
                    result_valid <= 1'b1;
                    result_class <= nb_cls;
                    result_score <= nb_score;
                    result_match <= (nb_score >= min_q);
                end
                WRITE: begin
                    state           <= DONE;
                    am_wen          <= 1'b0;
                    am_waddr        <= '0;
                    am_wdata        <= '0;
                    result_valid    <= 1'b1;
                    result_is_write <= 1'b1;
                end
                DONE: begin
                    if (result_ready) begin
                        state           <= IDLE;
                        query_ready     <= 1'b1;
                        result_valid    <= 1'b0;
                        result_class    <= '0;
                        result_score    <= '0;
                        result_match    <= 1'b0;
                        result_is_write <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_am_search_engine.sv
// Directed bench for am_search_engine: table of searches against a small behavioural AM,
// plus hand sequences for write, stall, soft clear and async reset.
module tb_am_search_engine;

    localparam int HV = 16;
    localparam int AW = 5;
    localparam int CW = 3;
    localparam int SW = 5;

    logic          clk = 1'b0;
    logic          rst_ni = 1'b0;
    logic          soft_clear = 1'b0;
    logic          query_valid = 1'b0;
    logic          query_ready;
    logic [HV-1:0] query_hv = '0;
    logic          query_write = 1'b0;
    logic [AW-1:0] addr_base = '0;
    logic [AW-1:0] addr_max = '0;
    logic [SW-1:0] min_score = '0;
    logic [AW-1:0] am_addr;
    logic          am_ren;
    logic [HV-1:0] am_rdata = '0;
    logic          am_wen;
    logic [AW-1:0] am_waddr;
    logic [HV-1:0] am_wdata;
    logic          result_valid;
    logic          result_ready = 1'b0;
    logic [CW-1:0] result_class;
    logic [SW-1:0] result_score;
    logic          result_match;
    logic          result_is_write;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    am_search_engine #(.HV_LENGTH(HV), .AM_ADDR_WIDTH(AW), .CLASS_WIDTH(CW)) dut (
        .clk_i(clk), .rst_ni(rst_ni), .soft_clear(soft_clear),
        .query_valid(query_valid), .query_ready(query_ready), .query_hv(query_hv),
        .query_write(query_write), .addr_base(addr_base), .addr_max(addr_max),
        .min_score(min_score), .am_addr(am_addr), .am_ren(am_ren), .am_rdata(am_rdata),
        .am_wen(am_wen), .am_waddr(am_waddr), .am_wdata(am_wdata),
        .result_valid(result_valid), .result_ready(result_ready),
        .result_class(result_class), .result_score(result_score),
        .result_match(result_match), .result_is_write(result_is_write)
    );

    // Behavioural AM: fixed preload, overridden by writes; one-cycle read latency.
    logic [HV-1:0] wmem [32];
    bit            wset [32];

    function automatic logic [HV-1:0] preload(input logic [AW-1:0] a);
        case (a)
            5'd0:    return 16'h001F;
            5'd1:    return 16'h01FF;
            5'd2:    return 16'hFF80;
            5'd3:    return 16'h0003;
            5'd9:    return 16'hFFFF;
            default: return (a >= 5'd10) ? 16'h0F0F : 16'h0000;
        endcase
    endfunction

    always @(posedge clk) begin
        if (am_wen) begin
            wmem[am_waddr] <= am_wdata;
            wset[am_waddr] <= 1'b1;
        end
        am_rdata <= am_ren ? (wset[am_addr] ? wmem[am_addr] : preload(am_addr)) : 16'hDEAD;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic start(input logic [HV-1:0] hv, input logic wr, input logic [AW-1:0] b,
                         input logic [AW-1:0] mx, input logic [SW-1:0] mn, input string tag);
        @(negedge clk);
        chk({tag, " ready_before_accept"}, query_ready, 1);
        query_valid = 1'b1; query_hv = hv; query_write = wr;
        addr_base = b; addr_max = mx; min_score = mn;
        @(posedge clk); #1;
        query_valid = 1'b0; query_hv = 16'h1234; query_write = 1'b0;
        addr_base = 5'd31; addr_max = 5'd0; min_score = 5'd31;
    endtask

    task automatic wait_res(output int cyc, output int ren, output int wen,
                            output logic [AW-1:0] wa, output logic [HV-1:0] wd);
        cyc = 1; ren = 0; wen = 0; wa = '0; wd = '0;
        while (cyc < 200) begin
            if (am_ren) ren++;
            if (am_wen) begin wen++; wa = am_waddr; wd = am_wdata; end
            if (result_valid) break;
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic release_res(input string tag);
        @(negedge clk);
        result_ready = 1'b1;
        @(posedge clk); #1;
        result_ready = 1'b0;
        chk({tag, " valid_after_release"}, result_valid, 0);
        chk({tag, " ready_after_release"}, query_ready, 1);
    endtask

    task automatic run(input logic [HV-1:0] hv, input logic wr, input logic [AW-1:0] b,
                       input logic [AW-1:0] mx, input logic [SW-1:0] mn, input int ecyc,
                       input int eren, input logic [CW-1:0] ecls, input logic [SW-1:0] esc,
                       input logic em, input string tag);
        int cyc, ren, wen;
        logic [AW-1:0] wa;
        logic [HV-1:0] wd;
        start(hv, wr, b, mx, mn, tag);
        wait_res(cyc, ren, wen, wa, wd);
        chk({tag, " latency"}, cyc, ecyc);
        chk({tag, " ren_cycles"}, ren, eren);
        chk({tag, " wen_cycles"}, wen, wr ? 1 : 0);
        if (wr) begin
            chk({tag, " waddr"}, wa, b);
            chk({tag, " wdata"}, wd, hv);
        end
        chk({tag, " class"}, result_class, ecls);
        chk({tag, " score"}, result_score, esc);
        chk({tag, " match"}, result_match, em);
        chk({tag, " is_write"}, result_is_write, wr);
        release_res(tag);
    endtask

    typedef struct {
        logic [HV-1:0] hv;
        logic [AW-1:0] b;
        logic [AW-1:0] mx;
        logic [SW-1:0] mn;
        int            cyc;
        int            ren;
        logic [CW-1:0] cls;
        logic [SW-1:0] sc;
        logic          m;
    } vec_t;

    vec_t vt [8];

    initial begin
        int cyc, ren, wen;
        logic [AW-1:0] wa;
        logic [HV-1:0] wd;
        bit bad_fields, bad_ready, seen_v, seen_r;

        //       hv        base  max   min   cyc ren cls sc  match
        vt[0] = '{16'hFFFF, 5'd0, 5'd3, 5'd8,  6,  4,  1,  9, 1'b1}; // scores 5,9,9,2
        vt[1] = '{16'h00FF, 5'd0, 5'd3, 5'd9,  6,  4,  1,  8, 1'b0}; // 5,8,1,2
        vt[2] = '{16'hFFFF, 5'd2, 5'd2, 5'd9,  3,  1,  0,  9, 1'b1};
        vt[3] = '{16'hFFFF, 5'd1, 5'd3, 5'd10, 5,  3,  0,  9, 1'b0}; // tie keeps lower
        vt[4] = '{16'hFFFF, 5'd0, 5'd9, 5'd16, 12, 10, 1, 16, 1'b1}; // class 9 truncated to 3 bits
        vt[5] = '{16'hFFFF, 5'd4, 5'd5, 5'd0,  4,  2,  0,  0, 1'b1};
        vt[6] = '{16'hFFFF, 5'd5, 5'd4, 5'd0,  1,  0,  0,  0, 1'b0}; // empty range
        vt[7] = '{16'h0F00, 5'd2, 5'd3, 5'd1,  4,  2,  0,  4, 1'b1}; // 4,0

        #1;
        chk("reset state", {query_ready, result_valid, am_ren, am_wen, am_addr, am_waddr, am_wdata,
                            result_class, result_score, result_match, result_is_write},
            {1'b1, 41'd0});
        @(negedge clk); rst_ni = 1'b1;

        for (int i = 0; i < 8; i++)
            run(vt[i].hv, 1'b0, vt[i].b, vt[i].mx, vt[i].mn, vt[i].cyc, vt[i].ren,
                vt[i].cls, vt[i].sc, vt[i].m, $sformatf("vec%0d", i));

        // Train then search the trained entry.
        run(16'hA5A5, 1'b1, 5'd7, 5'd0, 5'd0, 2, 0, 0, 0, 1'b0, "write");
        run(16'hFFFF, 1'b0, 5'd7, 5'd7, 5'd8, 3, 1, 0, 8, 1'b1, "readback");

        // Result stall with a competing query held valid.
        start(16'hFFFF, 1'b0, 5'd0, 5'd3, 5'd8, "stall");
        wait_res(cyc, ren, wen, wa, wd);
        chk("stall latency", cyc, 6);
        query_valid = 1'b1; query_hv = 16'hFFFF; addr_base = 5'd2; addr_max = 5'd2; min_score = 5'd9;
        bad_fields = 0; bad_ready = 0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            if ({result_valid, result_class, result_score, result_match, result_is_write} !==
                {1'b1, 3'd1, 5'd9, 1'b1, 1'b0}) bad_fields = 1;
            if (query_ready !== 1'b0) bad_ready = 1;
        end
        chk("stall fields stable", bad_fields, 0);
        chk("stall query_ready low", bad_ready, 0);
        @(negedge clk); result_ready = 1'b1;
        @(posedge clk); #1; result_ready = 1'b0;
        chk("stall release ready", query_ready, 1);
        @(posedge clk); #1;
        chk("stall next accepted", query_ready, 0);
        query_valid = 1'b0;
        wait_res(cyc, ren, wen, wa, wd);
        chk("stall next latency", cyc, 3);
        chk("stall next score", result_score, 9);
        release_res("stall next");

        // Soft clear in the middle of a 16-entry read burst.
        start(16'hFFFF, 1'b0, 5'd0, 5'd15, 5'd0, "sclr");
        repeat (3) begin @(posedge clk); #1; end
        chk("sclr in read", am_ren, 1);
        soft_clear = 1'b1;
        @(posedge clk); #1;
        soft_clear = 1'b0;
        chk("sclr am_ren", am_ren, 0);
        chk("sclr am_addr", am_addr, 0);
        chk("sclr query_ready", query_ready, 1);
        seen_v = 0; seen_r = 0;
        for (int k = 0; k < 20; k++) begin
            if (result_valid) seen_v = 1;
            if (am_ren) seen_r = 1;
            @(posedge clk); #1;
        end
        chk("sclr no result", seen_v, 0);
        chk("sclr no reads", seen_r, 0);

        // Async reset while draining, then a clean search.
        start(16'hFFFF, 1'b0, 5'd0, 5'd3, 5'd8, "arst");
        repeat (4) begin @(posedge clk); #1; end
        chk("arst in drain", {am_ren, result_valid, query_ready}, 0);
        #2 rst_ni = 1'b0;
        #1;
        chk("arst outputs", {query_ready, result_valid, am_ren, am_wen, am_addr, am_waddr, am_wdata,
                             result_class, result_score, result_match, result_is_write},
            {1'b1, 41'd0});
        #2 rst_ni = 1'b1;
        seen_v = 0; seen_r = 0;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            if (result_valid) seen_v = 1;
            if (am_ren || am_wen) seen_r = 1;
        end
        chk("arst no result", seen_v, 0);
        chk("arst no access", seen_r, 0);
        run(vt[0].hv, 1'b0, vt[0].b, vt[0].mx, vt[0].mn, vt[0].cyc, vt[0].ren,
            vt[0].cls, vt[0].sc, vt[0].m, "post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/am_search_engine.md
AM_SEARCH_ENGINE -- requirements
Module: am_search_engine

Interface
REQ-001 SHALL have parameter HV_LENGTH, default 2048, meaning hypervector width in bits.
REQ-002 SHALL have parameter AM_ADDR_WIDTH, default 13, meaning associative-memory address width.
REQ-003 SHALL have parameter CLASS_WIDTH, default 8, meaning class-index width.
REQ-004 SHALL have derived localparam SCORE_WIDTH = $clog2(HV_LENGTH+1), meaning popcount score width (12 at default).
REQ-005 SHALL have port clk_i  input  1  clock; all state updates on its rising edge.
REQ-006 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port soft_clear  input  1  synchronous abort to IDLE.
REQ-008 SHALL have port query_valid / query_ready  input / output  1 / 1  query handshake.
REQ-009 SHALL have port query_hv  input  HV_LENGTH  encoded hypervector.
REQ-010 SHALL have port query_write  input  1  1 = train (write query_hv), 0 = search.
REQ-011 SHALL have port addr_base / addr_max  input / input  AM_ADDR_WIDTH each  inclusive class range, sampled at query accept.
REQ-012 SHALL have port min_score  input  SCORE_WIDTH  match threshold, sampled at query accept.
REQ-013 SHALL have port am_addr / am_ren  output / output  AM_ADDR_WIDTH / 1  AM read port.
REQ-014 SHALL have port am_rdata  input  HV_LENGTH  read data, valid exactly 1 cycle after am_ren.
REQ-015 SHALL have port am_wen / am_waddr / am_wdata  output / output / output  1 / AM_ADDR_WIDTH / HV_LENGTH  AM write port.
REQ-016 SHALL have port result_valid / result_ready  output / input  1 / 1  result handshake.
REQ-017 SHALL have port result_class / result_score  output / output  CLASS_WIDTH / SCORE_WIDTH  winning index (addr - addr_base) and its score.
REQ-018 SHALL have port result_match / result_is_write  output / output  1 / 1  best score >= min_score; result stems from a write.

Function
REQ-019 SHALL implement FSM with states IDLE, READ, DRAIN, WRITE, DONE.
REQ-020 SHALL drive query_ready=1 only in IDLE; on accept, latch query_hv, query_write, addr_base, addr_max, min_score; clear best score/class.
REQ-021 SHALL, on accept with query_write=1, go to WRITE: one cycle of am_wen=1, am_waddr=addr_base, am_wdata=query_hv; then DONE with result_is_write=1, result_class=0, result_score=0, result_match=0.
REQ-022 SHALL, on accept with query_write=0 and addr_base<=addr_max, go to READ; in READ, assert am_ren=1 with am_addr=cur, starting at cur=addr_base and incrementing by 1 per cycle.
REQ-023 SHALL leave READ for DRAIN after the cycle with cur==addr_max; DRAIN SHALL last 1 cycle and go to DONE.
REQ-024 SHALL, in the cycle after each read, compute score=popcount(query & am_rdata); it SHALL replace best only if strictly greater (ties keep the lower address); the first read always loads best.
REQ-025 SHALL achieve search latency N+2 cycles from the accept edge to result_valid, where N=addr_max-addr_base+1.
REQ-026 SHALL, when addr_base>addr_max in search mode, go directly to DONE with class 0, score 0, match 0.
REQ-027 SHALL truncate result_class to the CLASS_WIDTH LSBs of (winning addr - addr_base).
REQ-028 SHALL hold result_valid and all result fields stable in DONE until result_ready=1, then return to IDLE; a new query SHALL be accepted no earlier than the next cycle.
REQ-029 SHALL drive am_ren=0 outside READ and am_wen=0 outside WRITE; am_addr, am_waddr, am_wdata SHALL be 0 when not in use.
REQ-030 SHALL, on soft_clear=1 in any state, go to IDLE next cycle and clear best and result registers; soft_clear SHALL take priority over all handshakes; a pending read return SHALL be discarded.
REQ-031 SHALL not block upstream: query_valid held while not ready has no effect, and query_hv SHALL be ignored after accept.

Reset
REQ-032 SHALL, while rst_ni=0: state=IDLE, query_ready=1, result_valid=0, am_ren=0, am_wen=0, all address/data/result outputs 0.
REQ-033 SHALL, on rst_ni assertion mid-search, abort immediately and issue no further AM accesses after release until a new query is accepted.

Verification
REQ-034 SHALL cover: search base=0, max=3, scores {5,9,9,2}, min_score=8 -> result_valid at cycle 6 after accept, class=1, score=9, match=1.
REQ-035 SHALL cover: write query, base=7 -> single am_wen pulse, am_waddr=7, am_wdata=query; result_is_write=1 one cycle later.
REQ-036 SHALL cover: base=5, max=4 -> result_valid 1 cycle after accept, class=0, score=0, match=0, no am_ren.
REQ-037 SHALL cover: result_ready held low 10 cycles -> fields stable, query_ready=0 throughout; query accepted only after release.
REQ-038 SHALL cover: soft_clear during READ of a 16-entry range -> IDLE next cycle, am_ren=0, result_valid never asserted.
REQ-039 SHALL cover: async rst_ni pulse mid-DRAIN -> all outputs 0 immediately; next search returns correct result.
